// File: rtl/enc_lookup_responder.sv
// enc_lookup_responder: responder side of the hash-encoding row lookup.
// Takes a column-request bitmask for one table row, reads every requested feature from the
// row's feature SRAM in ascending column order, and packs them into return beats of up to
// FEAT_PER_BEAT lanes. Each beat carries ret_num, the number of valid lanes it holds.
//
// Ports:
//   clk, rst                 clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready      request handshake; req_ready is high only while idle
//   req_mask                 bit i set = return the feature of column i
//   mem_rd_en/mem_rd_addr    SRAM read strobe and column index
//   mem_rd_data              SRAM read data, valid MEM_LAT cycles after mem_rd_en
//   ret_valid/ret_ready      return beat handshake
//   ret_data                 lane k = bits [k*DATA_WIDTH +: DATA_WIDTH], unused lanes zero
//   ret_num                  valid lanes in the beat, zero-extended
//   done                     one-cycle pulse once the request has been fully returned
module enc_lookup_responder #(
  parameter int unsigned TABLE_COL     = 128,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FEAT_PER_BEAT = 4,
  parameter int unsigned MEM_LAT       = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [TABLE_COL-1:0]                req_mask,
  output logic                                mem_rd_en,
  output logic [$clog2(TABLE_COL)-1:0]        mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]               mem_rd_data,
  output logic                                ret_valid,
  input  logic                                ret_ready,
  output logic [FEAT_PER_BEAT*DATA_WIDTH-1:0] ret_data,
  output logic [DATA_WIDTH-1:0]               ret_num,
  output logic                                done
);

  localparam int unsigned AW = $clog2(TABLE_COL);
  localparam int unsigned CW = $clog2(FEAT_PER_BEAT + 1);
  localparam int unsigned BW = FEAT_PER_BEAT * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               state_q, state_d;
  logic [TABLE_COL-1:0] pending_q, pending_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        buf_cnt_q, buf_cnt_d;
  logic [BW-1:0]        buf_q, buf_d;
  logic                 held_q, held_d;
  logic [DATA_WIDTH-1:0] ret_num_q, ret_num_d;
  logic [MEM_LAT-1:0]   rd_pipe_q, rd_pipe_d;
  logic                 done_q, done_d;
  logic                 req_ready_q, req_ready_d;

  logic [AW-1:0] lsb_idx;
  logic          issue;
  logic          capture;
  logic          accept;

  // Lowest set bit of the pending mask: the next column to read.
  always_comb begin
    lsb_idx = '0;
    for (int i = int'(TABLE_COL) - 1; i >= 0; i--) begin
      if (pending_q[i]) lsb_idx = AW'(i);
    end
  end

  // Reads are bounded so every outstanding read has a free lane waiting for it; this is
  // what guarantees no capture ever lands in a held beat.
  assign issue   = (state_q == StRun) && (pending_q != '0) &&
                   ((32'(inflight_q) + 32'(buf_cnt_q)) < FEAT_PER_BEAT);
  assign capture = rd_pipe_q[MEM_LAT-1];
  assign accept  = held_q && ret_ready;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    held_d      = held_q;
    ret_num_d   = ret_num_q;
    rd_pipe_d   = (rd_pipe_q << 1) | MEM_LAT'(issue);
    inflight_d  = inflight_q + CW'(issue) - CW'(capture);

    if (issue) pending_d = pending_q & (pending_q - TABLE_COL'(1));

    if (accept) begin
      buf_d     = '0;
      buf_cnt_d = '0;
      held_d    = 1'b0;
      ret_num_d = '0;
    end

    if (capture) begin
      for (int k = 0; k < int'(FEAT_PER_BEAT); k++) begin
        if (buf_cnt_d == CW'(k)) buf_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data;
      end
      buf_cnt_d = buf_cnt_d + CW'(1);
    end

    // A beat forms from next-state values so ret_valid rises right after the filling capture.
    if (!held_d && ((buf_cnt_d == CW'(FEAT_PER_BEAT)) ||
                    ((pending_d == '0) && (inflight_d == '0) && (buf_cnt_d != '0)))) begin
      held_d    = 1'b1;
      ret_num_d = DATA_WIDTH'(buf_cnt_d);
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_mask != '0) begin
            pending_d = req_mask;
            state_d   = StRun;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRun: begin
        if ((pending_d == '0) && (inflight_d == '0) && (buf_cnt_d == '0) && !held_d) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    done_d      = (state_d == StFin);
    req_ready_d = (state_d == StIdle);
  end

  // Clearing rd_pipe on reset drops any reads still in flight in the SRAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      inflight_q  <= '0;
      buf_cnt_q   <= '0;
      buf_q       <= '0;
      held_q      <= 1'b0;
      ret_num_q   <= '0;
      rd_pipe_q   <= '0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      inflight_q  <= inflight_d;
      buf_cnt_q   <= buf_cnt_d;
      buf_q       <= buf_d;
      held_q      <= held_d;
      ret_num_q   <= ret_num_d;
      rd_pipe_q   <= rd_pipe_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = lsb_idx;
  assign ret_valid   = held_q;
  assign ret_data    = buf_q;
  assign ret_num     = ret_num_q;
  assign done        = done_q;

endmodule

// File: tb/tb_enc_lookup_responder.sv
// Bench for enc_lookup_responder: SRAM model with fixed 2-cycle latency, scoreboard of
// expected read addresses and return beats filled when each request is driven.
module tb_enc_lookup_responder;

  localparam int TC  = 128;
  localparam int DW  = 32;
  localparam int FPB = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [TC-1:0]   req_mask = '0;
  logic            mem_rd_en;
  logic [6:0]      mem_rd_addr;
  logic [DW-1:0]   mem_rd_data;
  logic            ret_valid;
  logic            ret_ready = 1'b1;
  logic [127:0]    ret_data;
  logic [DW-1:0]   ret_num;
  logic            done;

  enc_lookup_responder #(
    .TABLE_COL    (TC),
    .DATA_WIDTH   (DW),
    .FEAT_PER_BEAT(FPB),
    .MEM_LAT      (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mask   (req_mask),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .ret_valid  (ret_valid),
    .ret_ready  (ret_ready),
    .ret_data   (ret_data),
    .ret_num    (ret_num),
    .done       (done)
  );

  always #5 clk = ~clk;

  // SRAM model: not reset, so reads issued before a reset still come back afterwards.
  logic [DW-1:0] mem [TC];
  logic          vp0 = 1'b0, vp1 = 1'b0;
  logic [6:0]    ap0 = '0, ap1 = '0;
  always @(posedge clk) begin
    vp0 <= mem_rd_en;
    vp1 <= vp0;
    ap0 <= mem_rd_addr;
    ap1 <= ap0;
  end
  assign mem_rd_data = vp1 ? mem[ap1] : 32'hBAD0_BAD0;

  // ret_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = never ready.
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       ret_ready = 1'b1;
      1:       ret_ready = ~ret_ready;
      default: ret_ready = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int           num;
    logic [127:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    exp_addr[$];

  int           acc_cyc = -1, first_rd_cyc = -1, first_ret_cyc = -1, done_cyc = -1;
  int           n_done = 0, num_sum = 0, outst = 0;
  bit           stall_pend = 1'b0;
  logic [127:0] stall_data;
  logic [DW-1:0] stall_num;

  task automatic push_expect(input logic [TC-1:0] mask);
    int           lanes = 0;
    logic [127:0] d = '0;
    beat_t        b;
    for (int i = 0; i < TC; i++) begin
      if (mask[i]) begin
        exp_addr.push_back(i);
        d[lanes*DW +: DW] = mem[i];
        lanes++;
        if (lanes == FPB) begin
          b.num = lanes; b.data = d; exp_q.push_back(b);
          lanes = 0; d = '0;
        end
      end
    end
    if (lanes > 0) begin
      b.num = lanes; b.data = d; exp_q.push_back(b);
    end
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exp_addr.delete();
    outst      = 0;
    stall_pend = 1'b0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (mem_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check_val("rd_credit", 128'(outst < FPB), 128'(1));
        outst++;
        if (exp_addr.size() == 0) check_val("rd_extra", 128'(mem_rd_addr), 128'hFFFF);
        else check_val("rd_addr", 128'(mem_rd_addr), 128'(exp_addr.pop_front()));
      end
      if (stall_pend) begin
        check_val("stall_hold", 128'(ret_valid), 128'(1));
        if (ret_valid) begin
          check_val("stall_data", ret_data, stall_data);
          check_val("stall_num", 128'(ret_num), 128'(stall_num));
        end
        stall_pend = 1'b0;
      end
      if (ret_valid) begin
        if (first_ret_cyc < 0) first_ret_cyc = cyc;
        if (ret_ready) begin
          if (exp_q.size() == 0) begin
            check_val("beat_extra", 128'(ret_num), 128'(0));
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            check_val("ret_num", 128'(ret_num), 128'(b.num));
            check_val("ret_data", ret_data, b.data);
          end
          num_sum += int'(ret_num);
          outst   -= int'(ret_num);
        end else begin
          stall_pend = 1'b1;
          stall_data = ret_data;
          stall_num  = ret_num;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_req(input logic [TC-1:0] mask, input bit poke_busy);
    push_expect(mask);
    acc_cyc = -1; first_rd_cyc = -1; first_ret_cyc = -1; done_cyc = -1; num_sum = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_mask  = mask;
    @(negedge clk);
    check_val("req_ready", 128'(req_ready), 128'(1));
    @(posedge clk); #1;
    if (poke_busy) begin
      // A different mask offered while busy must be ignored.
      req_mask = '1;
      repeat (3) begin
        @(negedge clk);
        check_val("busy_ready", 128'(req_ready), 128'(0));
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    req_mask  = '0;
  endtask

  task automatic run_req(input logic [TC-1:0] mask, input bit poke_busy);
    int n = 0;
    int nd0;
    nd0 = n_done;
    start_req(mask, poke_busy);
    while (done_cyc < 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("done_seen", 128'(done_cyc >= 0), 128'(1));
    @(negedge clk); #1;
    check_val("done_width", 128'(done), 128'(0));
    check_val("ready_after", 128'(req_ready), 128'(1));
    check_val("done_count", 128'(n_done - nd0), 128'(1));
    check_val("beats_left", 128'(exp_q.size()), 128'(0));
    check_val("addr_left", 128'(exp_addr.size()), 128'(0));
    check_val("num_sum", 128'(num_sum), 128'($countones(mask)));
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_req_ready"}, 128'(req_ready), 128'(1));
    check_val({tag, "_rd_en"}, 128'(mem_rd_en), 128'(0));
    check_val({tag, "_ret_valid"}, 128'(ret_valid), 128'(0));
    check_val({tag, "_ret_data"}, ret_data, 128'(0));
    check_val({tag, "_ret_num"}, 128'(ret_num), 128'(0));
    check_val({tag, "_done"}, 128'(done), 128'(0));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outs(tag);
    flush_sb();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [TC-1:0] m;
    int            n;
    for (int i = 0; i < TC; i++) mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;

    #1 rst = 1'b1;
    #1 check_reset_outs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single bit: exact latency.
    m = '0; m[5] = 1'b1;
    run_req(m, 1'b0);
    check_val("lat_rd", 128'(first_rd_cyc - acc_cyc), 128'(1));
    check_val("lat_ret", 128'(first_ret_cyc - acc_cyc), 128'(4));
    check_val("lat_done", 128'(done_cyc - acc_cyc), 128'(5));

    // Two full beats.
    m = '0; m[3:0] = 4'hF; m[11:8] = 4'hF;
    run_req(m, 1'b0);

    // Full beat then partial beat, with a request offered while busy.
    m = '0; m[3] = 1'b1; m[7] = 1'b1; m[20] = 1'b1; m[64] = 1'b1; m[100] = 1'b1; m[127] = 1'b1;
    run_req(m, 1'b1);

    // Full mask under back-pressure.
    rmode = 1;
    run_req('1, 1'b0);
    rmode = 0;
    repeat (2) @(negedge clk);

    // Zero mask.
    run_req('0, 1'b0);
    check_val("zero_done_lat", 128'(done_cyc - acc_cyc), 128'(1));
    check_val("zero_no_rd", 128'(first_rd_cyc), 128'(-1));
    check_val("zero_no_ret", 128'(first_ret_cyc), 128'(-1));

    // Reset with reads in flight; stale SRAM data must not appear afterwards.
    start_req('1, 1'b0);
    n = 0;
    while (first_rd_cyc < 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("rst1_rd_seen", 128'(first_rd_cyc >= 0), 128'(1));
    @(negedge clk);
    pulse_reset("rst1");

    // Reset with a beat held.
    rmode = 2;
    start_req('1, 1'b0);
    n = 0;
    while (!ret_valid && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("rst2_held", 128'(ret_valid), 128'(1));
    pulse_reset("rst2");
    rmode = 0;
    repeat (2) @(negedge clk);

    m = '0; m[9] = 1'b1;
    run_req(m, 1'b0);
    check_val("post_rst_lat", 128'(first_ret_cyc - acc_cyc), 128'(4));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/enc_lookup_responder.md
Name: enc_lookup_responder

Overview:
- Responder side of the hash-encoding row lookup protocol.
- Accepts a column-request bitmask for one table row and reads each requested feature from the row's feature SRAM, in ascending column order.
- Packs the features into return beats of up to FEAT_PER_BEAT lanes, each tagged with ret_num, the count of valid features in the beat.
- The initiator's return counter decrements by ret_num per beat, so the beats across one request sum exactly to the popcount of the mask.

Parameters:
- TABLE_COL, 128, columns per table row; width of req_mask.
- DATA_WIDTH, 32, width of one feature and of ret_num.
- FEAT_PER_BEAT, 4, feature lanes per return beat; must be >= 1.
- MEM_LAT, 2, fixed SRAM read latency in cycles; must be >= 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request mask valid.
- req_ready  out  1  high only in IDLE.
- req_mask  in  TABLE_COL  bit i set = return feature of column i.
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  $clog2(TABLE_COL)  column index being read.
- mem_rd_data  in  DATA_WIDTH  read data, valid MEM_LAT cycles after mem_rd_en.
- ret_valid  out  1  return beat valid.
- ret_ready  in  1  initiator accepts beat.
- ret_data  out  FEAT_PER_BEAT*DATA_WIDTH  lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- ret_num  out  DATA_WIDTH  valid lanes in beat, zero-extended, range 1..FEAT_PER_BEAT.
- done  out  1  one-cycle pulse: request fully returned.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE; pending mask, beat buffer, buf_cnt, inflight count and read-valid shift pipe all cleared.
  - req_ready=1, mem_rd_en=0, ret_valid=0, ret_data=0, ret_num=0, done=0.
  - Reads in flight at reset are discarded: their mem_rd_data is never captured.
- FSM states:
  - IDLE: req_ready=1. On req_valid & req_ready, latch req_mask into pending and go to RUN. If req_mask==0, go to FIN instead.
  - RUN: issue reads, collect data, emit beats. Go to FIN once pending==0, inflight==0, buf_cnt==0, and no beat is held.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Issue rule, evaluated each RUN cycle:
  - Condition: pending!=0 and inflight+buf_cnt < FEAT_PER_BEAT.
  - If true: mem_rd_en=1, mem_rd_addr = index of the lowest set bit of pending. That bit clears at the clock edge and inflight increments.
  - Credit from a beat accepted in the same cycle is not used; the freed space is available next cycle.
- Capture: data for a read issued in cycle c is sampled at the end of cycle c+MEM_LAT into lane buf_cnt. Then buf_cnt increments and inflight decrements.
- Beat formation:
  - Beat is held (registered ret_valid=1) the cycle after buf_cnt reaches FEAT_PER_BEAT, or the cycle after pending==0 & inflight==0 & buf_cnt>0 (partial last beat).
  - ret_num = buf_cnt at formation. Lanes >= ret_num are zero.
  - ret_data and ret_num stay stable while ret_valid & !ret_ready.
  - On ret_valid & ret_ready: buffer and buf_cnt clear. ret_valid drops next cycle unless a new beat forms.
  - No capture into a held beat is possible, because the issue rule bounds inflight+buf_cnt.
- Ordering: features leave in strictly ascending column order, lane 0 first.
- Latency, single-bit mask:
  - Accept in cycle 0, mem_rd_en in cycle 1, capture at end of cycle 1+MEM_LAT.
  - ret_valid in cycle 2+MEM_LAT; done in the cycle after the beat is accepted.
- Zero mask: accepted, no mem_rd_en, no beat; done in the cycle after acceptance.
- Full mask (all TABLE_COL bits): TABLE_COL/FEAT_PER_BEAT full beats, plus one partial beat of TABLE_COL mod FEAT_PER_BEAT if nonzero.
- req_valid outside IDLE is ignored: req_ready=0 and the mask is not sampled.

Test Plan:
- Mask bit 5 only, MEM_LAT=2, ret_ready=1 -> mem_rd_addr=5 in cycle 1; ret_valid in cycle 4 with ret_num=1, lane0=mem[5], lanes1-3=0; done in cycle 5.
- Mask bits {0,1,2,3,8,9,10,11} -> two beats, ret_num=4 each; lanes = mem[0..3] then mem[8..11]; done once.
- Mask bits {3,7,20,64,100,127} -> beats ret_num=4 (3,7,20,64) then ret_num=2 (100,127, lanes2-3=0); ret_num sum=6.
- All 128 bits, ret_ready toggling 1/0 every cycle -> 32 beats of ret_num=4, ascending; ret_data stable while stalled; mem_rd_en never drives inflight+buf_cnt above 4.
- req_mask=0 -> no mem_rd_en, no ret_valid; done high exactly 1 cycle after acceptance; req_ready back to 1 next cycle.
- Assert rst with 3 reads in flight and a beat held -> outputs at reset values immediately. After release, a mask with bit 9 set returns only mem[9], with no stale data.
